// File: rtl/cache_refill_controller.sv
// cache_refill_controller
//   Handles one cache miss at a time. It picks a victim way, reads the victim
//   line out of the array, writes it back as a burst if it is valid and dirty,
//   reads the missing line as a burst, and then writes it into the array.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   i_miss_*, o_miss_ready    miss request from the lookup side (accepted in IDLE)
//   i_way_valid/dirty         state bits of the missing set, sampled at accept
//   o_vrd_*, i_vrd_*          victim read strobe; tag and line return one cycle later
//   o_mem_req/we/addr, i_mem_ack   burst address phase
//   o_mem_wdata/wvalid, i_mem_wready  write-back beats
//   i_mem_rvalid/rdata        refill beats (always accepted)
//   o_fill_*                  one-cycle array write of the refilled line
//   o_busy                    high whenever a miss is in progress
module cache_refill_controller #(
    parameter int TAG_BITS        = 18,
    parameter int INDEX_BITS      = 8,
    parameter int OFFSET_BITS     = 6,
    parameter int LINE_SIZE_BYTES = 64,
    parameter int WAYS            = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss_valid,
    output logic                         o_miss_ready,
    input  logic [TAG_BITS-1:0]          i_miss_tag,
    input  logic [INDEX_BITS-1:0]        i_miss_index,
    input  logic [WAYS-1:0]              i_way_valid,
    input  logic [WAYS-1:0]              i_way_dirty,
    output logic                         o_vrd_en,
    output logic [INDEX_BITS-1:0]        o_vrd_index,
    output logic [$clog2(WAYS)-1:0]      o_vrd_way,
    input  logic [TAG_BITS-1:0]          i_vrd_tag,
    input  logic [LINE_SIZE_BYTES*8-1:0] i_vrd_data,
    output logic                         o_mem_req,
    output logic                         o_mem_we,
    output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
    input  logic                         i_mem_ack,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    output logic                         o_mem_wvalid,
    input  logic                         i_mem_wready,
    input  logic                         i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]        i_mem_rdata,
    output logic                         o_fill_en,
    output logic [INDEX_BITS-1:0]        o_fill_index,
    output logic [$clog2(WAYS)-1:0]      o_fill_way,
    output logic [TAG_BITS-1:0]          o_fill_tag,
    output logic [LINE_SIZE_BYTES*8-1:0] o_fill_data,
    output logic                         o_busy
);

    localparam int LINE_BITS = LINE_SIZE_BYTES * 8;
    localparam int BEATS     = LINE_BITS / DATA_WIDTH;
    localparam int WAY_W     = $clog2(WAYS);
    localparam int BEAT_W    = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE, VREAD, WB_ADDR, WB_DATA, RF_ADDR, RF_DATA, FILL
    } state_t;

    state_t                  state_q, state_d;
    logic                    vrd_capture_q;   // second VREAD cycle: array data is on i_vrd_*
    logic [WAY_W-1:0]        ptr_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [TAG_BITS-1:0]     miss_tag_q;
    logic [INDEX_BITS-1:0]   miss_index_q;
    logic [WAYS-1:0]         way_valid_q;
    logic [WAYS-1:0]         way_dirty_q;
    logic [TAG_BITS-1:0]     victim_tag_q;
    // Holds the victim line during write-back, then is overwritten beat by
    // beat with the refill; write-back always finishes before refill starts.
    logic [LINE_BITS-1:0]    line_q;

    logic [WAY_W-1:0]        victim_way;
    logic                    victim_from_ptr;
    logic                    beat_last;

    // Lowest invalid way wins; the round-robin pointer is only used when the set is full.
    always_comb begin
        victim_way      = ptr_q;
        victim_from_ptr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid_q[w]) begin
                victim_way      = WAY_W'(w);
                victim_from_ptr = 1'b0;
            end
        end
    end

    assign beat_last = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_miss_valid) state_d = VREAD;
            VREAD:   if (vrd_capture_q)
                         state_d = (way_valid_q[victim_way] && way_dirty_q[victim_way]) ? WB_ADDR : RF_ADDR;
            WB_ADDR: if (i_mem_ack) state_d = WB_DATA;
            WB_DATA: if (i_mem_wready && beat_last) state_d = RF_ADDR;
            RF_ADDR: if (i_mem_ack) state_d = RF_DATA;
            RF_DATA: if (i_mem_rvalid && beat_last) state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from state only; rst forces the idle values
    // immediately so nothing from an abandoned burst leaks out.
    always_comb begin
        o_miss_ready = 1'b0;
        o_busy       = 1'b0;
        o_vrd_en     = 1'b0;
        o_vrd_index  = '0;
        o_vrd_way    = '0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_wvalid = 1'b0;
        o_fill_en    = 1'b0;
        o_fill_index = '0;
        o_fill_way   = '0;
        o_fill_tag   = '0;
        o_fill_data  = '0;
        if (rst) begin
            o_miss_ready = 1'b1;
        end else begin
            o_busy = (state_q != IDLE);
            case (state_q)
                IDLE:    o_miss_ready = 1'b1;
                VREAD: begin
                    if (!vrd_capture_q) begin
                        o_vrd_en    = 1'b1;
                        o_vrd_index = miss_index_q;
                        o_vrd_way   = victim_way;
                    end
                end
                WB_ADDR: begin
                    o_mem_req  = 1'b1;
                    o_mem_we   = 1'b1;
                    o_mem_addr = {victim_tag_q, miss_index_q, {OFFSET_BITS{1'b0}}};
                end
                WB_DATA: begin
                    o_mem_wvalid = 1'b1;
                    o_mem_wdata  = line_q[int'(beat_q) * DATA_WIDTH +: DATA_WIDTH];
                end
                RF_ADDR: begin
                    o_mem_req  = 1'b1;
                    o_mem_addr = {miss_tag_q, miss_index_q, {OFFSET_BITS{1'b0}}};
                end
                FILL: begin
                    o_fill_en    = 1'b1;
                    o_fill_index = miss_index_q;
                    o_fill_way   = victim_way;
                    o_fill_tag   = miss_tag_q;
                    o_fill_data  = line_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            vrd_capture_q <= 1'b0;
            ptr_q         <= '0;
            beat_q        <= '0;
        end else begin
            state_q       <= state_d;
            vrd_capture_q <= (state_q == VREAD) && !vrd_capture_q;
            if ((state_d != state_q) && (state_d == WB_DATA || state_d == RF_DATA))
                beat_q <= '0;
            else if ((state_q == WB_DATA && i_mem_wready) || (state_q == RF_DATA && i_mem_rvalid))
                beat_q <= beat_q + 1'b1;
            // WAYS is a power of two, so the natural wrap is WAYS-1 -> 0.
            if (state_q == FILL && victim_from_ptr)
                ptr_q <= ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && i_miss_valid) begin
            miss_tag_q   <= i_miss_tag;
            miss_index_q <= i_miss_index;
            way_valid_q  <= i_way_valid;
            way_dirty_q  <= i_way_dirty;
        end
        if (state_q == VREAD && vrd_capture_q) begin
            victim_tag_q <= i_vrd_tag;
            line_q       <= i_vrd_data;
        end
        if (state_q == RF_DATA && i_mem_rvalid)
            line_q[int'(beat_q) * DATA_WIDTH +: DATA_WIDTH] <= i_mem_rdata;
    end

endmodule

// File: doc/cache_refill_controller.md
CACHE_REFILL_CONTROLLER -- requirements
Module: cache_refill_controller

Interface
REQ-001 Parameters SHALL be, one per line:
  TAG_BITS, 18, tag width
  INDEX_BITS, 8, set index width
  OFFSET_BITS, 6, byte offset width
  LINE_SIZE_BYTES, 64, line size in bytes
  WAYS, 4, associativity, power of two
  DATA_WIDTH, 32, memory bus width; beats per line BEATS = LINE_SIZE_BYTES*8/DATA_WIDTH (16)
  ADDRESS_WIDTH, 32, equals TAG_BITS+INDEX_BITS+OFFSET_BITS
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-high
  i_miss_valid  in  1  miss request from the lookup side
  o_miss_ready  out  1  high only in IDLE
  i_miss_tag  in  TAG_BITS  missing tag
  i_miss_index  in  INDEX_BITS  missing set
  i_way_valid  in  WAYS  valid bits of the set, sampled at accept
  i_way_dirty  in  WAYS  dirty bits of the set, sampled at accept
  o_vrd_en  out  1  victim read strobe, one cycle
  o_vrd_index  out  INDEX_BITS  victim set
  o_vrd_way  out  log2(WAYS)  victim way
  i_vrd_tag  in  TAG_BITS  victim tag, valid the cycle after o_vrd_en
  i_vrd_data  in  LINE_SIZE_BYTES*8  victim line, valid the cycle after o_vrd_en
  o_mem_req  out  1  address phase request
  o_mem_we  out  1  1 = write burst, 0 = read burst
  o_mem_addr  out  ADDRESS_WIDTH  line-aligned burst address
  i_mem_ack  in  1  address phase accepted
  o_mem_wdata  out  DATA_WIDTH  write beat
  o_mem_wvalid  out  1  write beat valid
  i_mem_wready  in  1  write beat accepted
  i_mem_rvalid  in  1  read beat valid, always accepted
  i_mem_rdata  in  DATA_WIDTH  read beat
  o_fill_en  out  1  one-cycle cache array write strobe
  o_fill_index  out  INDEX_BITS  set written
  o_fill_way  out  log2(WAYS)  way written
  o_fill_tag  out  TAG_BITS  tag written; valid=1, dirty=0, LRU updated by array
  o_fill_data  out  LINE_SIZE_BYTES*8  refilled line
  o_busy  out  1  high in every state except IDLE

Function
REQ-003 FSM states SHALL be IDLE, VREAD, WB_ADDR, WB_DATA, RF_ADDR, RF_DATA, FILL.
REQ-004 IDLE: on i_miss_valid && o_miss_ready, latch tag, index, valid and dirty bits; go VREAD.
REQ-005 Victim SHALL be the lowest-numbered way with valid=0; if all valid, the way given by a log2(WAYS)-bit round-robin pointer.
REQ-006 Pointer SHALL increment (wrapping WAYS-1 -> 0) at FILL only when the victim came from the pointer; otherwise it holds.
REQ-007 VREAD: o_vrd_en high exactly one cycle with latched index and victim way; next cycle latch i_vrd_tag and i_vrd_data.
REQ-008 After VREAD: victim valid and dirty -> WB_ADDR; else -> RF_ADDR.
REQ-009 WB_ADDR: o_mem_req=1, o_mem_we=1, o_mem_addr={victim tag, index, OFFSET_BITS zeros}; held stable until i_mem_ack, then WB_DATA.
REQ-010 WB_DATA: beat k SHALL be victim bits [DATA_WIDTH*k +: DATA_WIDTH], k = 0..BEATS-1; a beat advances only on o_mem_wvalid && i_mem_wready; wdata held stable while stalled; after beat BEATS-1 -> RF_ADDR.
REQ-011 RF_ADDR: o_mem_req=1, o_mem_we=0, o_mem_addr={miss tag, index, zeros}; held until i_mem_ack, then RF_DATA.
REQ-012 RF_DATA: each i_mem_rvalid beat k SHALL be stored at bits [DATA_WIDTH*k +: DATA_WIDTH]; gaps allowed; after beat BEATS-1 -> FILL.
REQ-013 FILL: o_fill_en high one cycle with latched index, victim way, miss tag and assembled line; next state IDLE, o_miss_ready high that next cycle.
REQ-014 i_mem_ack in the same cycle o_mem_req first rises SHALL complete the address phase in one cycle.
REQ-015 i_miss_valid outside IDLE SHALL be ignored; i_mem_rvalid outside RF_DATA and i_mem_ack without o_mem_req SHALL be ignored.
REQ-016 Beat counter SHALL be log2(BEATS) bits, cleared on entry to WB_DATA and RF_DATA.
REQ-017 Minimum miss latency, clean victim, no stalls, ack same cycle: accept to o_fill_en = 1 (VREAD) + 1 (capture) + 1 (RF_ADDR) + BEATS + 1 cycles.

Reset
REQ-018 rst SHALL take priority over all events, state -> IDLE, pointer -> 0, beat counter -> 0, abandoning any burst mid-transfer.
REQ-019 While rst is high and the cycle after, outputs SHALL be: o_miss_ready=1, o_busy=0; o_vrd_en, o_mem_req, o_mem_we, o_mem_wvalid, o_fill_en = 0; all data/address outputs 0.

Verification
REQ-020 Clean miss, i_way_valid=4'b0101: tag 0x2A, index 0x10 -> RF_ADDR addr 0x000A8400, no write burst, fill way 1, pointer stays 0.
REQ-021 All valid, way 0 dirty, pointer 0 -> write burst to victim tag address with 16 beats in order, then read burst; fill way 0; pointer becomes 1.
REQ-022 Random i_mem_wready/i_mem_rvalid gaps -> wdata stable while stalled; o_fill_data equals the concatenation of the 16 read beats.
REQ-023 Four all-valid clean misses -> victim ways 0,1,2,3, fifth miss wraps to 0.
REQ-024 rst asserted during WB_DATA beat 7 -> next cycle IDLE, o_mem_wvalid=0, o_miss_ready=1, no o_fill_en; new miss completes normally.
REQ-025 i_miss_valid held high while busy -> exactly one accept per completed FILL.
